// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : PC owner + prefetch FIFO feeding decode (valid/ready)
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fetch_en,
  output logic [31:0]      read_address,
  input  logic [31:0]      instruction,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instruction,
  output logic [31:0]      out_pc,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_mem_q    [FIFO_DEPTH];
  logic [31:0]      pc_mem_d    [FIFO_DEPTH];
  logic [31:0]      instr_mem_q [FIFO_DEPTH];
  logic [31:0]      instr_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop;
  logic             push;
  logic             unused_target_bits;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Word alignment discards the low target bits.
  assign unused_target_bits = ^redirect_target[1:0];

  always_comb begin
    pop         = (count_q != '0) & out_ready & ~redirect_valid;
    push        = fetch_en & ~redirect_valid & ((count_q < DEPTH_CNT) | pop);
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (redirect_valid) begin
      pc_d    = {redirect_target[31:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_mem_d[tail_q]    = pc_q;
        instr_mem_d[tail_q] = instruction;
        tail_d              = ptr_next(tail_q);
        pc_d                = pc_q + 32'd4;
      end
      if (pop) begin
        head_d = ptr_next(head_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  // A redirect hides the head in the same cycle it is flushed.
  assign out_valid       = (count_q != '0) & ~redirect_valid;
  assign out_instruction = out_valid ? instr_mem_q[head_q] : 32'h0;
  assign out_pc          = out_valid ? pc_mem_q[head_q] : 32'h0;
  assign read_address    = pc_q;
  assign fifo_count      = count_q;

endmodule

`default_nettype wire
